// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked set/reset command driver for an asynchronous S/R latch with enable
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake, accept when both high
//   cmd_level          1 = set (Qa->1), 0 = reset (Qa->0), captured on accept
//   S, R, Enable       registered latch drive
//   Qa, Qb             asynchronous latch feedback
//   busy               high from the cycle after accept until done/err
//   done, err          1-cycle completion / timeout pulses
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int GUARD_W = 2,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_level,
    output logic cmd_ready,
    output logic S,
    output logic R,
    output logic Enable,
    input  logic Qa,
    input  logic Qb,
    output logic busy,
    output logic done,
    output logic err
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic             qa_m, qa_s, qb_m, qb_s;
    logic             accept, match, expired;

    assign accept  = cmd_valid && cmd_ready;
    // 00 and 11 can never equal {lvl, ~lvl}, so they always count as a mismatch
    assign match   = (qa_s == lvl) && (qb_s == ~lvl);
    assign expired = cnt == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa_m <= 1'b0;
            qa_s <= 1'b0;
            qb_m <= 1'b0;
            qb_s <= 1'b0;
        end else begin
            qa_m <= Qa;
            qa_s <= qa_m;
            qb_m <= Qb;
            qb_s <= qb_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lvl       <= 1'b0;
            cmd_ready <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            Enable    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= !accept;
                    if (accept) begin
                        state  <= SETUP;
                        lvl    <= cmd_level;
                        cnt    <= CNT_W'(GUARD_W - 1);
                        Enable <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                SETUP: begin
                    cnt <= expired ? CNT_W'(PULSE_W - 1) : cnt - 1'b1;
                    if (expired) begin
                        state <= PULSE;
                        S     <= lvl;
                        R     <= !lvl;
                    end
                end
                PULSE: begin
                    cnt <= expired ? CNT_W'(GUARD_W - 1) : cnt - 1'b1;
                    if (expired) begin
                        state <= HOLD;
                        S     <= 1'b0;
                        R     <= 1'b0;
                    end
                end
                HOLD: begin
                    cnt <= expired ? CNT_W'(TIMEOUT - 1) : cnt - 1'b1;
                    if (expired) begin
                        state  <= CHECK;
                        Enable <= 1'b0;
                    end
                end
                CHECK: begin
                    cnt <= cnt - 1'b1;
                    if (match || expired) begin
                        state     <= IDLE;
                        done      <= match;
                        err       <= !match;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed self-checking bench for sr_latch_driver
module tb_sr_latch_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_level = 1'b0;
    logic cmd_ready, S, R, Enable, Qa, Qb, busy, done, err;

    logic lq = 1'b0;
    logic force_en = 1'b0;
    logic fqa = 1'b0;
    logic fqb = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int both_n, de_n;
    logic [31:0] en_v, s_v, r_v, done_v, err_v, rdy_v, busy_v, acc_v;

    sr_latch_driver #(.PULSE_W(4), .GUARD_W(2), .TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_level(cmd_level),
        .cmd_ready(cmd_ready), .S(S), .R(R), .Enable(Enable), .Qa(Qa), .Qb(Qb),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // behavioural latch: transparent while Enable, holds otherwise
    always @(S, R, Enable) begin
        if (Enable && S && !R) lq = 1'b1;
        else if (Enable && R && !S) lq = 1'b0;
    end
    assign Qa = force_en ? fqa : lq;
    assign Qb = force_en ? fqb : ~lq;

    // issue one command at the current negedge (cycle 0) and record n cycles
    task automatic capture(input logic lvl, input int n);
        en_v = '0; s_v = '0; r_v = '0; done_v = '0; err_v = '0; rdy_v = '0; busy_v = '0;
        both_n = 0; de_n = 0;
        cmd_level = lvl;
        cmd_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == 1) cmd_valid = 1'b0;
            en_v[i] = Enable; s_v[i] = S; r_v[i] = R; done_v[i] = done;
            err_v[i] = err; rdy_v[i] = cmd_ready; busy_v[i] = busy;
            if (S && R) both_n++;
            if (done && err) de_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, S, R, Enable, busy, done, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000000", {cmd_ready, S, R, Enable, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_set();
        capture(1'b1, 12);
        n_checks++;
        if (en_v !== 32'h1FE) begin n_fail++; $display("FAIL set_enable: got %h want 000001fe", en_v); end
        n_checks++;
        if (s_v !== 32'h78) begin n_fail++; $display("FAIL set_s: got %h want 00000078", s_v); end
        n_checks++;
        if (r_v !== 32'h0) begin n_fail++; $display("FAIL set_r: got %h want 00000000", r_v); end
        n_checks++;
        if (done_v !== 32'h400 || err_v !== 32'h0) begin
            n_fail++;
            $display("FAIL set_done: done %h err %h want 00000400 00000000", done_v, err_v);
        end
        n_checks++;
        if (rdy_v !== 32'hC01 || busy_v !== 32'h3FE) begin
            n_fail++;
            $display("FAIL set_ready_busy: ready %h busy %h want 00000c01 000003fe", rdy_v, busy_v);
        end
        n_checks++;
        if (Qa !== 1'b1 || Qb !== 1'b0) begin n_fail++; $display("FAIL set_latch: Qa=%b Qb=%b want 1 0", Qa, Qb); end
    endtask

    task automatic test_clear();
        capture(1'b0, 12);
        n_checks++;
        if (r_v !== 32'h78 || s_v !== 32'h0) begin
            n_fail++;
            $display("FAIL clr_sr: r %h s %h want 00000078 00000000", r_v, s_v);
        end
        n_checks++;
        if (done_v !== 32'h400 || en_v !== 32'h1FE) begin
            n_fail++;
            $display("FAIL clr_done_en: done %h en %h want 00000400 000001fe", done_v, en_v);
        end
        n_checks++;
        if (Qa !== 1'b0 || Qb !== 1'b1) begin n_fail++; $display("FAIL clr_latch: Qa=%b Qb=%b want 0 1", Qa, Qb); end
    endtask

    task automatic test_stuck(input logic a, input logic b);
        force_en = 1'b1; fqa = a; fqb = b;
        capture(1'b1, 19);
        n_checks++;
        if (err_v !== 32'h20000 || done_v !== 32'h0) begin
            n_fail++;
            $display("FAIL stuck%b%b_err: err %h done %h want 00020000 00000000", a, b, err_v, done_v);
        end
        n_checks++;
        if (rdy_v !== 32'h60001 || busy_v !== 32'h1FFFE) begin
            n_fail++;
            $display("FAIL stuck%b%b_ready_busy: ready %h busy %h want 00060001 0001fffe", a, b, rdy_v, busy_v);
        end
        n_checks++;
        if (en_v !== 32'h1FE || s_v !== 32'h78) begin
            n_fail++;
            $display("FAIL stuck%b%b_drive: en %h s %h want 000001fe 00000078", a, b, en_v, s_v);
        end
        force_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int w;
        acc_v = '0; rdy_v = '0; s_v = '0; r_v = '0; both_n = 0; de_n = 0;
        cmd_level = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0 && acc_v[i-1]) cmd_level = ~cmd_level;
            acc_v[i] = cmd_valid && cmd_ready;
            rdy_v[i] = cmd_ready; s_v[i] = S; r_v[i] = R;
            if (S && R) both_n++;
            if (done && err) de_n++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (acc_v !== 32'h100401) begin n_fail++; $display("FAIL b2b_accepts: got %h want 00100401", acc_v); end
        n_checks++;
        if (s_v !== 32'h07800078 || r_v !== 32'h0001E000) begin
            n_fail++;
            $display("FAIL b2b_sr: s %h r %h want 07800078 0001e000", s_v, r_v);
        end
        n_checks++;
        if (both_n != 0 || de_n != 0) begin
            n_fail++;
            $display("FAIL b2b_exclusive: s&r %0d done&err %0d want 0 0", both_n, de_n);
        end
        w = 0;
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        n_checks++;
        if (cmd_ready !== 1'b1 || Qa !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_final: ready=%b Qa=%b want 1 1", cmd_ready, Qa);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic r_seen;
        logic bad;
        cmd_level = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) cmd_valid = 1'b0;
            @(negedge clk);
        end
        r_seen = R && Enable;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!r_seen || {S, R, Enable, cmd_ready, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: before R&En=%b after %b want 1 00000", r_seen, {S, R, Enable, cmd_ready, busy});
        end
        @(posedge clk);
        #1;
        bad = done || err || Enable || cmd_ready;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bad || cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_release: glitch=%b ready=%b done=%b err=%b want 0 1 0 0", bad, cmd_ready, done, err);
        end
        capture(1'b1, 12);
        n_checks++;
        if (done_v !== 32'h400 || s_v !== 32'h78 || en_v !== 32'h1FE) begin
            n_fail++;
            $display("FAIL mid_reset_recover: done %h s %h en %h want 00000400 00000078 000001fe", done_v, s_v, en_v);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_clear();
        test_stuck(1'b0, 1'b1);
        test_stuck(1'b1, 1'b1);
        test_back_to_back();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
